// File: rtl/csr_tohost_unit.sv
// Owner of the tohost CSR: decodes CSR ops, holds tohost, latches a sticky verdict and RUN cycle count.
// Optional watchdog is compiled in with TOHOST_TIMEOUT_EN.
module csr_tohost_unit #(
  parameter logic [11:0] CSR_ADDR = 12'h51e,
  parameter int          CYCLE_W  = 32
`ifdef TOHOST_TIMEOUT_EN
  ,
  parameter int          TIMEOUT  = 10000
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               csr_valid,
  output logic               csr_ready,
  input  logic [11:0]        csr_addr,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        csr_wdata,
  output logic               csr_rvalid,
  output logic [31:0]        csr_rdata,
  output logic [31:0]        tohost,
  output logic               test_done,
  output logic               test_pass,
  output logic               test_timeout,
  output logic [30:0]        fail_id,
  output logic [CYCLE_W-1:0] cycle_count
);

  // state   | meaning
  // RUN     | test executing, cycle_count advancing
  // DONE    | tohost written with bit0=1, verdict frozen
  // TIMEOUT | watchdog expired before completion, verdict frozen
  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DONE    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;
  localparam logic [CYCLE_W-1:0] CNT_MAX = '1;

  state_t             state, state_nxt;
  logic               accept, hit, wr_en, done_wr, wd_expired;
  logic [31:0]        tohost_new;
  logic               done_nxt, pass_nxt, timeout_nxt;
  logic [30:0]        fail_id_nxt;
  logic [CYCLE_W-1:0] cnt_nxt;
  logic               timeout_q;

  assign csr_ready = 1'b1;
  assign accept    = csr_valid && csr_ready;
  assign hit       = accept && (csr_addr == CSR_ADDR) && (csr_op != OP_NONE);

  // Set/clear with a zero mask is the read-only CSR form and must not write.
  always_comb begin
    tohost_new = csr_wdata;
    wr_en      = hit;
    case (csr_op)
      OP_RW: tohost_new = csr_wdata;
      OP_RS: begin
        tohost_new = tohost | csr_wdata;
        wr_en      = hit && (csr_wdata != '0);
      end
      OP_RC: begin
        tohost_new = tohost & ~csr_wdata;
        wr_en      = hit && (csr_wdata != '0);
      end
      default: wr_en = 1'b0;
    endcase
  end

  assign done_wr = wr_en && tohost_new[0] && (state == ST_RUN);

`ifdef TOHOST_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

  // Down-counter reaches zero exactly when cycle_count == TIMEOUT-1.
  logic [WD_W-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= WD_LOAD;
    end else if ((state == ST_RUN) && (wd_cnt != '0)) begin
      wd_cnt <= wd_cnt - 1'b1;
    end
  end

  assign wd_expired   = (wd_cnt == '0);
  assign test_timeout = timeout_q;
`else
  assign wd_expired   = 1'b0;
  assign test_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    done_nxt    = test_done;
    pass_nxt    = test_pass;
    timeout_nxt = timeout_q;
    fail_id_nxt = fail_id;
    cnt_nxt     = cycle_count;
    case (state)
      ST_RUN: begin
        if (done_wr) begin
          state_nxt   = ST_DONE;
          done_nxt    = 1'b1;
          pass_nxt    = (tohost_new[31:1] == '0);
          fail_id_nxt = tohost_new[31:1];
        end else if (wd_expired) begin
          state_nxt   = ST_TIMEOUT;
          done_nxt    = 1'b1;
          pass_nxt    = 1'b0;
          timeout_nxt = 1'b1;
        end else if (cycle_count != CNT_MAX) begin
          cnt_nxt = cycle_count + 1'b1;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_RUN;
      tohost      <= '0;
      csr_rdata   <= '0;
      csr_rvalid  <= 1'b0;
      test_done   <= 1'b0;
      test_pass   <= 1'b0;
      timeout_q   <= 1'b0;
      fail_id     <= '0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      test_done   <= done_nxt;
      test_pass   <= pass_nxt;
      timeout_q   <= timeout_nxt;
      fail_id     <= fail_id_nxt;
      cycle_count <= cnt_nxt;
      csr_rvalid  <= accept;
      csr_rdata   <= hit ? tohost : '0;
      if (wr_en) begin
        tohost <= tohost_new;
      end
    end
  end

`ifndef TOHOST_TIMEOUT_EN
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_csr_tohost_unit.sv
// Directed self-checking bench for csr_tohost_unit; watchdog steps follow TOHOST_TIMEOUT_EN.
module tb_csr_tohost_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_valid = 1'b0;
  logic        csr_ready;
  logic [11:0] csr_addr = '0;
  logic [1:0]  csr_op = '0;
  logic [31:0] csr_wdata = '0;
  logic        csr_rvalid;
  logic [31:0] csr_rdata;
  logic [31:0] tohost;
  logic        test_done;
  logic        test_pass;
  logic        test_timeout;
  logic [30:0] fail_id;
  logic [31:0] cycle_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_tohost_unit #(
    .CSR_ADDR(12'h51e),
    .CYCLE_W (32)
`ifdef TOHOST_TIMEOUT_EN
    ,
    .TIMEOUT (50)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_valid   (csr_valid),
    .csr_ready   (csr_ready),
    .csr_addr    (csr_addr),
    .csr_op      (csr_op),
    .csr_wdata   (csr_wdata),
    .csr_rvalid  (csr_rvalid),
    .csr_rdata   (csr_rdata),
    .tohost      (tohost),
    .test_done   (test_done),
    .test_pass   (test_pass),
    .test_timeout(test_timeout),
    .fail_id     (fail_id),
    .cycle_count (cycle_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic req(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    csr_valid = 1'b1;
    csr_addr  = a;
    csr_op    = op;
    csr_wdata = wd;
    tick();
    csr_valid = 1'b0;
    csr_op    = 2'b00;
    csr_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    csr_valid = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tohost"}, tohost, 0);
    check({tag, "_rdata"}, csr_rdata, 0);
    check({tag, "_rvalid"}, csr_rvalid, 0);
    check({tag, "_ready"}, csr_ready, 1);
    check({tag, "_done"}, test_done, 0);
    check({tag, "_pass"}, test_pass, 0);
    check({tag, "_timeout"}, test_timeout, 0);
    check({tag, "_fail_id"}, fail_id, 0);
    check({tag, "_count"}, cycle_count, 0);
  endtask

  initial begin
    #3;
    check_all_zero("reset");

    // Pass: csrwi 0x51e,1 on the first edge
    @(negedge clk);
    rst_n = 1'b1;
    req(12'h51e, 2'b01, 32'h1);
    check("pass_tohost", tohost, 32'h1);
    check("pass_done", test_done, 1);
    check("pass_pass", test_pass, 1);
    check("pass_fail_id", fail_id, 0);
    check("pass_rdata", csr_rdata, 0);
    check("pass_rvalid", csr_rvalid, 1);
    check("pass_count", cycle_count, 0);
    tick();
    check("pass_rvalid_pulse", csr_rvalid, 0);
    check("pass_count_frozen", cycle_count, 0);

    // Fail id 3, then later write of 1 keeps the sticky verdict
    do_reset();
    tick(2);
    check("fail_count_run", cycle_count, 2);
    req(12'h51e, 2'b01, 32'h7);
    check("fail_tohost", tohost, 32'h7);
    check("fail_done", test_done, 1);
    check("fail_pass", test_pass, 0);
    check("fail_id", fail_id, 3);
    check("fail_count", cycle_count, 2);
    tick();
    req(12'h51e, 2'b01, 32'h1);
    check("fail_rewrite_tohost", tohost, 32'h1);
    check("fail_rewrite_rdata", csr_rdata, 32'h7);
    check("fail_sticky_pass", test_pass, 0);
    check("fail_sticky_id", fail_id, 3);

    // Back-to-back RW/RS/RC
    do_reset();
    req(12'h51e, 2'b01, 32'hF0);
    check("b2b_tohost0", tohost, 32'hF0);
    check("b2b_rdata0", csr_rdata, 32'h0);
    check("b2b_done0", test_done, 0);
    req(12'h51e, 2'b10, 32'h01);
    check("b2b_tohost1", tohost, 32'hF1);
    check("b2b_rdata1", csr_rdata, 32'hF0);
    check("b2b_done1", test_done, 1);
    check("b2b_fail_id1", fail_id, 31'h78);
    check("b2b_count1", cycle_count, 1);
    req(12'h51e, 2'b11, 32'h10);
    check("b2b_tohost2", tohost, 32'hE1);
    check("b2b_rdata2", csr_rdata, 32'hF1);
    check("b2b_rvalid2", csr_rvalid, 1);
    check("b2b_fail_id2", fail_id, 31'h78);
    check("b2b_pass2", test_pass, 0);

    // Non-hit and read-only accesses
    do_reset();
    req(12'h300, 2'b01, 32'h1);
    check("miss_rvalid", csr_rvalid, 1);
    check("miss_rdata", csr_rdata, 0);
    check("miss_tohost", tohost, 0);
    check("miss_done", test_done, 0);
    req(12'h51e, 2'b01, 32'h6);
    check("ro_setup_tohost", tohost, 32'h6);
    req(12'h51e, 2'b10, 32'h0);
    check("rs0_rdata", csr_rdata, 32'h6);
    check("rs0_tohost", tohost, 32'h6);
    check("rs0_done", test_done, 0);
    req(12'h51e, 2'b11, 32'h0);
    check("rc0_rdata", csr_rdata, 32'h6);
    check("rc0_tohost", tohost, 32'h6);
    req(12'h51e, 2'b00, 32'h1);
    check("opnone_rvalid", csr_rvalid, 1);
    check("opnone_rdata", csr_rdata, 0);
    check("opnone_tohost", tohost, 32'h6);
    check("opnone_done", test_done, 0);

    // Asynchronous reset mid-RUN
    do_reset();
    req(12'h51e, 2'b01, 32'h40);
    tick(19);
    check("mid_tohost", tohost, 32'h40);
    check("mid_count", cycle_count, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("restart_count", cycle_count, 1);

`ifdef TOHOST_TIMEOUT_EN
    do_reset();
    tick(49);
    check("wd_pre_timeout", test_timeout, 0);
    check("wd_pre_count", cycle_count, 49);
    tick();
    check("wd_timeout", test_timeout, 1);
    check("wd_done", test_done, 1);
    check("wd_pass", test_pass, 0);
    check("wd_count", cycle_count, 49);
    tick(5);
    check("wd_count_frozen", cycle_count, 49);
    req(12'h51e, 2'b01, 32'h1);
    check("wd_tohost_writable", tohost, 32'h1);
    check("wd_sticky_pass", test_pass, 0);
    check("wd_sticky_timeout", test_timeout, 1);

    // Done-write in the expiry cycle wins
    do_reset();
    tick(49);
    req(12'h51e, 2'b01, 32'h1);
    check("race_done", test_done, 1);
    check("race_pass", test_pass, 1);
    check("race_timeout", test_timeout, 0);
    check("race_count", cycle_count, 49);
`else
    do_reset();
    tick(100);
    check("nowd_done", test_done, 0);
    check("nowd_timeout", test_timeout, 0);
    check("nowd_count", cycle_count, 100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
